// File: rtl/dma_periph_pkg.sv
// dma_periph_pkg: shared constants, FSM state type and pointer helper for the peripheral request handler
package dma_periph_pkg;
  localparam int NUM_CH = 31;
  localparam int CH_W = 5;
  localparam int NUM_ENT = 2 * NUM_CH;
  localparam int IDX_W = 6;
  localparam logic DIR_TX = 1'b0;
  localparam logic DIR_RX = 1'b1;
  typedef enum logic [2:0] {IDLE, START, BUSY, CLR, DROP} state_t;
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_ENT - 1)) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/periph_rr_arb.sv
// periph_rr_arb: 62-entry round-robin arbiter; req in, search start ptr in, winner idx/valid out (combinational)
module periph_rr_arb
  import dma_periph_pkg::*;
(
  input  logic [NUM_ENT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  always_comb begin
    idx = '0;
    valid = 1'b0;
    sum = '0;
    cand = '0;
    // walk offsets from farthest to nearest so the entry closest to ptr wins last
    for (int k = NUM_ENT - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      cand = (sum >= (IDX_W + 1)'(NUM_ENT)) ? IDX_W'(sum - (IDX_W + 1)'(NUM_ENT)) : sum[IDX_W-1:0];
      if (req[cand]) begin
        idx = cand;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/periph_modport.sv
// periph_modport: round-robin peripheral DMA request handler; tx/rx req+en in, ch_start/ch_num/ch_dir/ch_busy and clr pulses out, ch_done in
module periph_modport
  import dma_periph_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH:1]   periph_tx_req,
  input  logic [NUM_CH:1]   periph_rx_req,
  output logic [NUM_CH:1]   periph_tx_clr,
  output logic [NUM_CH:1]   periph_rx_clr,
  input  logic [NUM_CH:1]   tx_en,
  input  logic [NUM_CH:1]   rx_en,
  output logic              ch_start,
  output logic [CH_W-1:0]   ch_num,
  output logic              ch_dir,
  output logic              ch_busy,
  input  logic              ch_done
);
  logic [NUM_CH:1]    tx_q;
  logic [NUM_CH:1]    rx_q;
  logic [NUM_ENT-1:0] pend;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur;
  logic [IDX_W-1:0]   win;
  logic               win_v;
  logic [NUM_CH:1]    oh;
  logic               cur_req;
  state_t             state;
  for (genvar c = 1; c <= NUM_CH; c++) begin : g_pend
    assign pend[2*c-2] = tx_q[c] & tx_en[c];
    assign pend[2*c-1] = rx_q[c] & rx_en[c];
  end
  periph_rr_arb u_arb (
    .req   (pend),
    .ptr   (ptr),
    .idx   (win),
    .valid (win_v)
  );
  assign oh = NUM_CH'(1) << (ch_num - 1'b1);
  // registered level of the granted entry, used to hold off re-grant of a stale request
  assign cur_req = |(oh & ((ch_dir == DIR_RX) ? rx_q : tx_q));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cur <= '0;
      tx_q <= '0;
      rx_q <= '0;
      ch_start <= 1'b0;
      ch_busy <= 1'b0;
      ch_num <= '0;
      ch_dir <= DIR_TX;
      periph_tx_clr <= '0;
      periph_rx_clr <= '0;
    end else begin
      tx_q <= periph_tx_req;
      rx_q <= periph_rx_req;
      case (state)
        IDLE: if (win_v) begin
          cur <= win;
          ch_num <= CH_W'(win[IDX_W-1:1]) + 1'b1;
          ch_dir <= win[0];
          ch_start <= 1'b1;
          ch_busy <= 1'b1;
          state <= START;
        end
        START: begin
          ch_start <= 1'b0;
          state <= BUSY;
        end
        BUSY: if (ch_done) begin
          ch_busy <= 1'b0;
          periph_tx_clr <= (ch_dir == DIR_TX) ? oh : '0;
          periph_rx_clr <= (ch_dir == DIR_RX) ? oh : '0;
          state <= CLR;
        end
        CLR: begin
          periph_tx_clr <= '0;
          periph_rx_clr <= '0;
          ptr <= next_idx(cur);
          state <= DROP;
        end
        DROP: if (!cur_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_periph_modport.sv
// tb_periph_modport: scoreboard-driven self-checking bench for periph_modport
module tb_periph_modport;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:1] tx_req = '0, rx_req = '0, tx_en = '1, rx_en = '1, tx_clr, rx_clr;
  logic ch_start, ch_dir, ch_busy, ch_done = 1'b0;
  logic [4:0] ch_num;
  int tests = 0, fails = 0;
  logic [5:0] exp_q[$];
  localparam logic [5:0] NONE = 6'd0;

  always #5 clk = ~clk;

  periph_modport dut (
    .clk(clk), .reset(reset),
    .periph_tx_req(tx_req), .periph_rx_req(rx_req),
    .periph_tx_clr(tx_clr), .periph_rx_clr(rx_clr),
    .tx_en(tx_en), .rx_en(rx_en),
    .ch_start(ch_start), .ch_num(ch_num), .ch_dir(ch_dir), .ch_busy(ch_busy),
    .ch_done(ch_done)
  );

  function automatic logic [31:1] oh(input logic [4:0] c);
    return 31'(1) << (c - 5'd1);
  endfunction

  function automatic logic [5:0] ent(input logic [4:0] c, input logic d);
    return {c, d};
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tx_req = '0;
    rx_req = '0;
    tx_en = '1;
    rx_en = '1;
    ch_done = 1'b0;
    exp_q.delete();
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_start(input int lim, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    while (!ok && n < lim) begin
      tick;
      n++;
      ok = ch_start;
    end
  endtask

  // called at the negedge where ch_start is seen; pulses ch_done in BUSY and gathers clr activity
  task automatic finish_xfer(output logic [31:1] tc, output logic [31:1] rc, output int cnt,
                             output int maxb, output logic busy1, output logic start1);
    tick;
    start1 = ch_start;
    busy1 = ch_busy;
    ch_done = 1'b1;
    tick;
    ch_done = 1'b0;
    tc = '0;
    rc = '0;
    cnt = 0;
    maxb = 0;
    for (int i = 0; i < 4; i++) begin
      if (|{tx_clr, rx_clr}) cnt++;
      if ($countones({tx_clr, rx_clr}) > maxb) maxb = $countones({tx_clr, rx_clr});
      tc |= tx_clr;
      rc |= rx_clr;
      tick;
    end
  endtask

  // peripheral model: wait for grant, pop the scoreboard, optionally raise another request, complete, drop
  task automatic serve(input bit drop, input logic [5:0] raise, output bit ok, output int n,
                       output logic [5:0] got, output logic [5:0] want, output logic [31:1] tc,
                       output logic [31:1] rc, output int cnt, output int maxb);
    logic b1, s1;
    wait_start(20, ok, n);
    got = '0;
    want = '0;
    tc = '0;
    rc = '0;
    cnt = 0;
    maxb = 0;
    if (!ok) return;
    got = {ch_num, ch_dir};
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
    if (raise[5:1] != 5'd0) begin
      if (raise[0]) rx_req[raise[5:1]] = 1'b1;
      else tx_req[raise[5:1]] = 1'b1;
      exp_q.push_back(raise);
    end
    finish_xfer(tc, rc, cnt, maxb, b1, s1);
    if (drop) begin
      if (got[0]) rx_req[got[5:1]] = 1'b0;
      else tx_req[got[5:1]] = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tests++;
    if ({ch_start, ch_busy, ch_num, ch_dir} !== 8'd0) begin
      fails++;
      $display("FAIL reset_ctl start=%b busy=%b num=%0d dir=%b want all 0", ch_start, ch_busy, ch_num, ch_dir);
    end
    tests++;
    if ({tx_clr, rx_clr} !== 62'd0) begin
      fails++;
      $display("FAIL reset_clr tx=%h rx=%h want 0", tx_clr, rx_clr);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    bit ok;
    int n, cnt, maxb;
    logic [5:0] got, want;
    logic [31:1] tc, rc;
    logic b1, s1;
    apply_reset;
    exp_q.push_back(ent(5, 0));
    tx_req[5] = 1'b1;
    wait_start(20, ok, n);
    tests++;
    if (!ok || n != 2) begin
      fails++;
      $display("FAIL single_latency seen=%b cycles=%0d want seen=1 cycles=2", ok, n);
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
    tests++;
    if ({ch_num, ch_dir} !== want) begin
      fails++;
      $display("FAIL single_grant ch=%0d dir=%b want ch=%0d dir=%b", ch_num, ch_dir, want[5:1], want[0]);
    end
    finish_xfer(tc, rc, cnt, maxb, b1, s1);
    tests++;
    if (s1 !== 1'b0 || b1 !== 1'b1) begin
      fails++;
      $display("FAIL single_pulse start=%b busy=%b want start=0 busy=1", s1, b1);
    end
    tests++;
    if (tc !== oh(5) || rc !== '0 || cnt != 1 || maxb != 1) begin
      fails++;
      $display("FAIL single_clr tx=%h rx=%h cycles=%0d bits=%0d want tx=%h rx=0 cycles=1 bits=1", tc, rc, cnt, maxb, oh(5));
    end
    tx_req[5] = 1'b0;
    repeat (4) tick;
    rx_req[6] = 1'b1;
    exp_q.push_back(ent(6, 1));
    serve(1'b1, NONE, ok, n, got, want, tc, rc, cnt, maxb);
    tests++;
    if (!ok || got !== want || n != 2 || rc !== oh(6) || tc !== '0 || cnt != 1) begin
      fails++;
      $display("FAIL single_idle_regrant seen=%b n=%0d ch=%0d dir=%b rx=%h want ch=6 dir=1 n=2 rx=%h", ok, n, got[5:1], got[0], rc, oh(6));
    end
  endtask

  task automatic test_rr;
    bit ok;
    int n, cnt, maxb;
    logic [5:0] got, want;
    logic [31:1] tc, rc;
    apply_reset;
    tx_req[3] = 1'b1;
    rx_req[3] = 1'b1;
    tx_req[31] = 1'b1;
    exp_q.push_back(ent(3, 0));
    exp_q.push_back(ent(3, 1));
    exp_q.push_back(ent(31, 0));
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, (i == 2) ? ent(3, 0) : NONE, ok, n, got, want, tc, rc, cnt, maxb);
      tests++;
      if (!ok || got !== want || tc !== (want[0] ? '0 : oh(want[5:1])) ||
          rc !== (want[0] ? oh(want[5:1]) : '0) || cnt != 1 || maxb != 1) begin
        fails++;
        $display("FAIL rr_grant%0d seen=%b ch=%0d dir=%b tx=%h rx=%h cycles=%0d want ch=%0d dir=%b", i, ok, got[5:1], got[0], tc, rc, cnt, want[5:1], want[0]);
      end
    end
  endtask

  task automatic test_mask;
    bit ok;
    int n, cnt, maxb;
    logic [5:0] got, want;
    logic [31:1] tc, rc;
    apply_reset;
    rx_en[7] = 1'b0;
    rx_req[7] = 1'b1;
    wait_start(8, ok, n);
    tests++;
    if (ok) begin
      fails++;
      $display("FAIL mask_blocked start seen with ch=%0d dir=%b want no start", ch_num, ch_dir);
    end
    rx_en[7] = 1'b1;
    exp_q.push_back(ent(7, 1));
    serve(1'b1, NONE, ok, n, got, want, tc, rc, cnt, maxb);
    tests++;
    if (!ok || got !== want || rc !== oh(7) || tc !== '0 || cnt != 1) begin
      fails++;
      $display("FAIL mask_enabled seen=%b ch=%0d dir=%b rx=%h want ch=7 dir=1 rx=%h", ok, got[5:1], got[0], rc, oh(7));
    end
  endtask

  task automatic test_stale;
    bit ok;
    int n, cnt, maxb;
    logic [5:0] got, want;
    logic [31:1] tc, rc;
    apply_reset;
    tx_req[2] = 1'b1;
    exp_q.push_back(ent(2, 0));
    serve(1'b0, NONE, ok, n, got, want, tc, rc, cnt, maxb);
    tests++;
    if (!ok || got !== want || tc !== oh(2) || cnt != 1) begin
      fails++;
      $display("FAIL stale_first seen=%b ch=%0d dir=%b tx=%h want ch=2 dir=0 tx=%h", ok, got[5:1], got[0], tc, oh(2));
    end
    wait_start(4, ok, n);
    tests++;
    if (ok) begin
      fails++;
      $display("FAIL stale_hold regrant of ch=%0d dir=%b want none while level held", ch_num, ch_dir);
    end
    tx_req[2] = 1'b0;
    tick;
    tick;
    tx_req[2] = 1'b1;
    exp_q.push_back(ent(2, 0));
    serve(1'b1, NONE, ok, n, got, want, tc, rc, cnt, maxb);
    tests++;
    if (!ok || got !== want || tc !== oh(2) || cnt != 1) begin
      fails++;
      $display("FAIL stale_reassert seen=%b ch=%0d dir=%b tx=%h want ch=2 dir=0 tx=%h", ok, got[5:1], got[0], tc, oh(2));
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n, cnt, maxb;
    logic [5:0] got, want;
    logic [31:1] tc, rc;
    apply_reset;
    tx_req[5] = 1'b1;
    exp_q.push_back(ent(5, 0));
    serve(1'b1, NONE, ok, n, got, want, tc, rc, cnt, maxb);
    tests++;
    if (!ok || got !== want || tc !== oh(5)) begin
      fails++;
      $display("FAIL rmid_pre seen=%b ch=%0d dir=%b want ch=5 dir=0", ok, got[5:1], got[0]);
    end
    tx_req[9] = 1'b1;
    exp_q.push_back(ent(9, 0));
    wait_start(20, ok, n);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
    tests++;
    if (!ok || {ch_num, ch_dir} !== want) begin
      fails++;
      $display("FAIL rmid_grant seen=%b ch=%0d dir=%b want ch=9 dir=0", ok, ch_num, ch_dir);
    end
    tick;
    tx_req[3] = 1'b1;
    tick;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({ch_start, ch_busy, ch_num, ch_dir, tx_clr, rx_clr} !== 70'd0) begin
      fails++;
      $display("FAIL rmid_async start=%b busy=%b num=%0d dir=%b tx=%h rx=%h want all 0", ch_start, ch_busy, ch_num, ch_dir, tx_clr, rx_clr);
    end
    tick;
    tests++;
    if ({tx_clr, rx_clr} !== 62'd0 || ch_busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_noclr tx=%h rx=%h busy=%b want 0", tx_clr, rx_clr, ch_busy);
    end
    reset = 1'b0;
    exp_q.push_back(ent(3, 0));
    exp_q.push_back(ent(9, 0));
    for (int i = 0; i < 2; i++) begin
      serve(1'b1, NONE, ok, n, got, want, tc, rc, cnt, maxb);
      tests++;
      if (!ok || got !== want || tc !== oh(want[5:1]) || cnt != 1) begin
        fails++;
        $display("FAIL rmid_after%0d seen=%b ch=%0d dir=%b tx=%h want ch=%0d dir=%b", i, ok, got[5:1], got[0], tc, want[5:1], want[0]);
      end
    end
  endtask

  task automatic test_spurious;
    bit ok;
    int n, cnt, maxb;
    logic [5:0] got, want;
    logic [31:1] tc, rc;
    logic act;
    apply_reset;
    ch_done = 1'b1;
    tick;
    ch_done = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 4; i++) begin
      act |= (|{tx_clr, rx_clr, ch_busy, ch_start});
      tick;
    end
    tests++;
    if (act !== 1'b0) begin
      fails++;
      $display("FAIL spurious_done activity=%b want 0", act);
    end
    tx_req[4] = 1'b1;
    exp_q.push_back(ent(4, 0));
    serve(1'b1, NONE, ok, n, got, want, tc, rc, cnt, maxb);
    tests++;
    if (!ok || n != 2 || got !== want || tc !== oh(4) || cnt != 1) begin
      fails++;
      $display("FAIL spurious_idle seen=%b n=%0d ch=%0d dir=%b tx=%h want n=2 ch=4 dir=0 tx=%h", ok, n, got[5:1], got[0], tc, oh(4));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_rr;
    test_mask;
    test_stale;
    test_reset_mid;
    test_spurious;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_empty left=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
